// File: rtl/gate_vector_sequencer.sv
// rtl/gate_vector_sequencer.sv - Built-in self-test sequencer for the two-input basic gate block
//
// Drives all four {a,b} combinations into the gate block, lets each vector
// settle for SETTLE_CYCLES cycles, samples the eight gate outputs and compares
// them against the fixed truth table. Reports pass/fail per vector.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   sweep request, honoured only when idle
//   a, b       out  1   gate block inputs
//   gate_in    in   8   {nota,notb,or,nor,and,nand,xor,xnor}, [7]=nota
//   busy       out  1   sweep in progress (excludes the done cycle)
//   done       out  1   one-cycle pulse when results become valid
//   pass       out  1   all four vectors matched
//   fail_vec   out  4   bit i set when vector {a,b}=i mismatched
//   err_count  out  3   number of mismatched vectors
//   capture    out  32  raw samples, capture[8*i+:8] for vector i

module gate_vector_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        a,
    output logic        b,
    input  logic [7:0]  gate_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_vec,
    output logic [2:0]  err_count,
    output logic [31:0] capture
);

    // A settle time of zero still needs one cycle for a,b to reach the block.
    localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int unsigned CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        ab_q, ab_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       capture_q, capture_d;
    logic [3:0]        fail_vec_q, fail_vec_d;
    logic [2:0]        err_count_q, err_count_d;
    logic              pass_q, pass_d;

    logic              mismatch;
    logic [2:0]        err_next;

    // Expected gate outputs for vector {a,b}=i.
    function automatic logic [7:0] exp_vec(input logic [1:0] i);
        logic [7:0] r;
        case (i)
            2'd0:    r = 8'hD5;
            2'd1:    r = 8'hA6;
            2'd2:    r = 8'h66;
            default: r = 8'h29;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ab_d        = ab_q;
        cnt_d       = cnt_q;
        capture_d   = capture_q;
        fail_vec_d  = fail_vec_q;
        err_count_d = err_count_q;
        pass_d      = pass_q;

        mismatch    = (gate_in != exp_vec(idx_q));
        err_next    = err_count_q + {2'b00, mismatch};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_SETTLE;
                    idx_d       = 2'd0;
                    ab_d        = 2'b00;
                    cnt_d       = '0;
                    capture_d   = '0;
                    fail_vec_d  = '0;
                    err_count_d = '0;
                    pass_d      = 1'b0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                capture_d[{idx_q, 3'b000} +: 8] = gate_in;
                if (mismatch) begin
                    fail_vec_d[idx_q] = 1'b1;
                end
                err_count_d = err_next;
                if (idx_q == 2'd3) begin
                    state_d = S_DONE;
                    // Includes this final compare, so pass is valid in the done cycle.
                    pass_d  = (err_next == 3'd0);
                end else begin
                    state_d = S_SETTLE;
                    idx_d   = idx_q + 2'd1;
                    ab_d    = idx_q + 2'd1;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ab_d    = 2'b00;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 2'd0;
            ab_q        <= 2'b00;
            cnt_q       <= '0;
            capture_q   <= '0;
            fail_vec_q  <= '0;
            err_count_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ab_q        <= ab_d;
            cnt_q       <= cnt_d;
            capture_q   <= capture_d;
            fail_vec_q  <= fail_vec_d;
            err_count_q <= err_count_d;
            pass_q      <= pass_d;
        end
    end

    assign a         = ab_q[1];
    assign b         = ab_q[0];
    assign busy      = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign fail_vec  = fail_vec_q;
    assign err_count = err_count_q;
    assign capture   = capture_q;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// tb/tb_gate_vector_sequencer.sv - Directed self-checking bench for gate_vector_sequencer

module tb_gate_vector_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance 2: SETTLE_CYCLES=2, combinational model with optional xor stuck-at-0
    logic        start2 = 1'b0, a2, b2, busy2, done2, pass2;
    logic [3:0]  fv2;
    logic [2:0]  ec2;
    logic [31:0] cap2;
    logic [7:0]  gin2;
    logic        fault2 = 1'b0;

    // Instance 1: SETTLE_CYCLES=1, gate model with one cycle of delay
    logic        start1 = 1'b0, a1, b1, busy1, done1, pass1;
    logic [3:0]  fv1;
    logic [2:0]  ec1;
    logic [31:0] cap1;
    logic [7:0]  gin1 = 8'h00;

    // Instance 0: SETTLE_CYCLES=0, combinational model
    logic        start0 = 1'b0, a0, b0, busy0, done0, pass0;
    logic [3:0]  fv0;
    logic [2:0]  ec0;
    logic [31:0] cap0;
    logic [7:0]  gin0;

    function automatic logic [7:0] gate_model(input logic a, input logic b);
        return {~a, ~b, a | b, ~(a | b), a & b, ~(a & b), a ^ b, ~(a ^ b)};
    endfunction

    assign gin2 = gate_model(a2, b2) & (fault2 ? 8'hFD : 8'hFF);
    assign gin0 = gate_model(a0, b0);
    always @(posedge clk) gin1 <= gate_model(a1, b1);

    gate_vector_sequencer #(.SETTLE_CYCLES(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .gate_in(gin2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_vec(fv2), .err_count(ec2), .capture(cap2)
    );
    gate_vector_sequencer #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .gate_in(gin1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_vec(fv1), .err_count(ec1), .capture(cap1)
    );
    gate_vector_sequencer #(.SETTLE_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .gate_in(gin0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_vec(fv0), .err_count(ec0), .capture(cap0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       start0 = v;
            1:       start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic get_outs(input int sel, output logic [1:0] ab, output logic bz,
                            output logic dn, output logic ps, output logic [3:0] fv,
                            output logic [2:0] ec, output logic [31:0] cp);
        case (sel)
            0:       begin ab = {a0, b0}; bz = busy0; dn = done0; ps = pass0; fv = fv0; ec = ec0; cp = cap0; end
            1:       begin ab = {a1, b1}; bz = busy1; dn = done1; ps = pass1; fv = fv1; ec = ec1; cp = cap1; end
            default: begin ab = {a2, b2}; bz = busy2; dn = done2; ps = pass2; fv = fv2; ec = ec2; cp = cap2; end
        endcase
    endtask

    // One full sweep on instance sel; spv = edges per vector (settle + sample).
    task automatic sweep(input string tag, input int sel, input int spv, input logic [31:0] exp_cap,
                         input logic [3:0] exp_fv, input logic [2:0] exp_ec, input logic exp_pass,
                         input bit repulse);
        logic [1:0] ab; logic bz, dn, ps; logic [3:0] fv; logic [2:0] ec; logic [31:0] cp;
        int done_seen;
        done_seen = 0;
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(sel, 1'b0);
        get_outs(sel, ab, bz, dn, ps, fv, ec, cp);
        chk({tag, "_accept_busy"}, {31'd0, bz}, 32'd1);
        chk({tag, "_accept_ab"}, {30'd0, ab}, 32'd0);
        for (int e = 1; e <= 4 * spv; e++) begin
            set_start(sel, (repulse && (e == 3 || e == 7)) ? 1'b1 : 1'b0);
            @(posedge clk);
            @(negedge clk);
            get_outs(sel, ab, bz, dn, ps, fv, ec, cp);
            if (dn) done_seen++;
            if (e < 4 * spv) begin
                chk($sformatf("%s_ab_e%0d", tag, e), {30'd0, ab}, e / spv);
                chk($sformatf("%s_busy_e%0d", tag, e), {31'd0, bz}, 32'd1);
            end
        end
        set_start(sel, 1'b0);
        chk({tag, "_done_pulse"}, {31'd0, dn}, 32'd1);
        chk({tag, "_done_count"}, done_seen, 32'd1);
        chk({tag, "_done_busy"}, {31'd0, bz}, 32'd0);
        chk({tag, "_pass"}, {31'd0, ps}, {31'd0, exp_pass});
        chk({tag, "_fail_vec"}, {28'd0, fv}, {28'd0, exp_fv});
        chk({tag, "_err_count"}, {29'd0, ec}, {29'd0, exp_ec});
        chk({tag, "_capture"}, cp, exp_cap);
        @(posedge clk);
        @(negedge clk);
        get_outs(sel, ab, bz, dn, ps, fv, ec, cp);
        chk({tag, "_idle_done"}, {31'd0, dn}, 32'd0);
        chk({tag, "_idle_busy"}, {31'd0, bz}, 32'd0);
        chk({tag, "_idle_ab"}, {30'd0, ab}, 32'd0);
        chk({tag, "_hold_pass"}, {31'd0, ps}, {31'd0, exp_pass});
        chk({tag, "_hold_capture"}, cp, exp_cap);
    endtask

    initial begin
        logic [1:0] ab; logic bz, dn, ps; logic [3:0] fv; logic [2:0] ec; logic [31:0] cp;
        int ndone, first_done, prev_done, busy_low;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        get_outs(2, ab, bz, dn, ps, fv, ec, cp);
        chk("rst_ab", {30'd0, ab}, 32'd0);
        chk("rst_busy", {31'd0, bz}, 32'd0);
        chk("rst_done", {31'd0, dn}, 32'd0);
        chk("rst_pass", {31'd0, ps}, 32'd0);
        chk("rst_fv_ec", {25'd0, fv, ec}, 32'd0);
        chk("rst_capture", cp, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean sweep and fault sweep
        sweep("clean", 2, 3, 32'h2966A6D5, 4'b0000, 3'd0, 1'b1, 1'b0);
        fault2 = 1'b1;
        sweep("xor_sa0", 2, 3, 32'h2964A4D5, 4'b0110, 3'd2, 1'b0, 1'b0);
        fault2 = 1'b0;

        // Re-pulsed start during busy is ignored
        sweep("repulse", 2, 3, 32'h2966A6D5, 4'b0000, 3'd0, 1'b1, 1'b1);

        // Asynchronous reset mid-vector 1
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        repeat (4) @(posedge clk);
        get_outs(2, ab, bz, dn, ps, fv, ec, cp);
        chk("pre_rst_capture", cp, 32'h000000D5);
        #2;
        rst_n = 1'b0;
        #1;
        get_outs(2, ab, bz, dn, ps, fv, ec, cp);
        chk("async_rst_ab", {30'd0, ab}, 32'd0);
        chk("async_rst_busy", {31'd0, bz}, 32'd0);
        chk("async_rst_capture", cp, 32'd0);
        chk("async_rst_flags", {24'd0, dn, ps, fv, ec}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done2) ndone++;
        end
        chk("no_done_after_rst", ndone, 32'd0);
        sweep("after_rst", 2, 3, 32'h2966A6D5, 4'b0000, 3'd0, 1'b1, 1'b0);

        // start held high: back-to-back sweeps, results cleared at each accept
        fault2 = 1'b1;
        ndone = 0; first_done = 0; prev_done = 0; busy_low = 0;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 45; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (!busy2) busy_low++;
            if (ndone >= 1 && e == first_done + 2) begin
                chk("held_accept_busy", {31'd0, busy2}, 32'd1);
                chk("held_accept_cleared", {28'd0, pass2, ec2}, 32'd0);
                chk("held_accept_fv", {28'd0, fv2}, 32'd0);
            end
            if (done2) begin
                if (ndone == 0) begin
                    first_done = e;
                    chk("held_first_done_edge", e, 32'd12);
                    chk("held_first_fv", {28'd0, fv2}, 32'h6);
                    chk("held_first_pass", {31'd0, pass2}, 32'd0);
                    fault2 = 1'b0;
                end else begin
                    chk($sformatf("held_period_%0d", ndone), e - prev_done, 32'd14);
                    chk($sformatf("held_pass_%0d", ndone), {31'd0, pass2}, 32'd1);
                end
                prev_done = e;
                ndone++;
            end
        end
        start2 = 1'b0;
        chk("held_done_count", ndone, 32'd3);
        chk("held_busy_low_cycles", busy_low, 32'd6);
        repeat (20) @(negedge clk);

        // Minimum settle: SETTLE_CYCLES=1 with delayed model, and 0 treated as 1
        sweep("settle1_dly", 1, 2, 32'h2966A6D5, 4'b0000, 3'd0, 1'b1, 1'b0);
        sweep("settle0", 0, 2, 32'h2966A6D5, 4'b0000, 3'd0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
